// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding imem requests,
// fills the F/D slot under stall, and applies D-stage redirects after one delay slot.
module fetch_ctrl #(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(32'h0000_3000)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch,
  input  logic [AW-1:0] npc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  output logic          if_valid,
  output logic [31:0]   if_instr,
  output logic [AW-1:0] if_pc,
  output logic [AW-1:0] if_pc8
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_pc, w_pc_n;
  logic [AW-1:0] r_tgt, w_tgt_n;
  logic          r_if_valid, w_if_valid_n;
  logic [31:0]   r_if_instr, w_if_instr_n;
  logic [AW-1:0] r_if_pc, w_if_pc_n;
  logic [AW-1:0] r_if_pc8, w_if_pc8_n;

  logic w_slot_free;
  logic w_req;
  logic w_fetch_done;
  logic w_accept;
  logic w_squash;
  logic w_load;

  assign w_slot_free  = !r_if_valid || !stall;
  assign w_req        = (r_state != BOOT) && w_slot_free && reset;
  assign w_fetch_done = w_req && imem_ready;
  assign w_accept     = branch && !stall && (r_state != BOOT);
  // Word fetched alongside a redirect whose delay slot is already in F is wrong-path.
  assign w_squash     = (r_state == RUN) && w_accept && r_if_valid && w_fetch_done;
  assign w_load       = w_fetch_done && !w_squash;

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign if_pc8    = r_if_pc8;

  // Next-state, PC sequencing and slot update.
  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_tgt_n      = r_tgt;
    w_if_valid_n = r_if_valid;
    w_if_instr_n = r_if_instr;
    w_if_pc_n    = r_if_pc;
    w_if_pc8_n   = r_if_pc8;

    if (w_load) begin
      w_if_valid_n = 1'b1;
      w_if_instr_n = imem_rdata;
      w_if_pc_n    = r_pc;
      w_if_pc8_n   = r_pc + AW'(8);
    end else if (w_squash || (r_if_valid && !stall)) begin
      w_if_valid_n = 1'b0;
    end

    if (w_fetch_done) begin
      w_pc_n = r_pc + AW'(4);
    end

    case (r_state)
      BOOT: w_state_n = RUN;
      RUN: begin
        if (w_accept) begin
          if (r_if_valid || w_fetch_done) begin
            w_pc_n = npc;
          end else begin
            w_tgt_n   = npc;
            w_state_n = PEND;
          end
        end
      end
      PEND: begin
        // A second redirect while waiting for the delay slot replaces the target.
        if (w_accept) begin
          w_tgt_n = npc;
        end
        if (w_fetch_done) begin
          w_pc_n    = w_accept ? npc : r_tgt;
          w_state_n = RUN;
        end
      end
      default: w_state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_tgt      <= '0;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_if_pc8   <= AW'(8);
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_tgt      <= w_tgt_n;
      r_if_valid <= w_if_valid_n;
      r_if_instr <= w_if_instr_n;
      r_if_pc    <= w_if_pc_n;
      r_if_pc8   <= w_if_pc8_n;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the five-stage pipeline. It owns the architectural PC register and issues single-outstanding requests to instruction memory. It delivers fetched words into the F/D slot under the hazard unit's stall. It applies branch/jump redirects produced by the D-stage next-PC logic with MIPS one-instruction delay-slot semantics.

## Interface
Parameters:
- RESET_PC, 32'h00003000, PC loaded on reset and first fetch address
- AW, 32, address/PC width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-low; reset asserted when reset==0
- stall  in  1  hazard-unit stall; F/D slot and PC frozen while 1
- branch  in  1  D-stage redirect valid (taken branch, j, jal, jr)
- npc  in  32  D-stage redirect target, sampled only when branch && !stall
- imem_req  out  1  fetch request, address on imem_addr
- imem_addr  out  32  fetch address (= pc register)
- imem_ready  in  1  memory accepts request and returns imem_rdata same cycle
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready
- if_valid  out  1  F/D slot holds an instruction
- if_instr  out  32  instruction in F/D slot
- if_pc  out  32  address of if_instr
- if_pc8  out  32  if_pc + 8, link value for jal

## Operation
- FSM states: BOOT, RUN, PEND.
  - Reset -> BOOT.
  - BOOT -> RUN unconditionally next cycle; imem_req=0 in BOOT.
- slot_free = !if_valid || !stall.
- imem_req = (state != BOOT) && slot_free && reset; combinational.
- fetch_done = imem_req && imem_ready.
- On fetch_done:
  - if_instr <= imem_rdata, if_pc <= pc, if_valid <= 1.
  - pc <= pc+4 unless redirected (below).
- Slot consumed (if_valid && !stall) with no fetch_done: if_valid <= 0.
- Redirect is accepted only when branch && !stall; branch under stall is ignored (D re-asserts it).
- Accept with if_valid==1, no fetch_done (delay slot already in F):
  - pc <= npc; state stays RUN.
- Accept with if_valid==1 and fetch_done (fetched word is wrong-path pc+4 of delay slot):
  - Squash it: if_valid <= 0.
  - pc <= npc.
- Accept with if_valid==0 and fetch_done (fetched word is the delay slot):
  - Load it normally.
  - pc <= npc.
- Accept with if_valid==0, no fetch_done (delay slot not yet fetched):
  - tgt <= npc; state <= PEND.
- PEND: on fetch_done, load the delay slot normally, pc <= tgt, state <= RUN.
- branch accepted while in PEND: tgt overwritten with new npc (undefined at ISA level, defined here).
- Arithmetic is modulo 2^32: pc+4 and if_pc+8 wrap silently; low two bits of npc are passed through unchecked.

## Timing
- Reset values: pc=RESET_PC, state=BOOT, tgt=0, if_valid=0, if_instr=0, if_pc=0, if_pc8=8, imem_req=0.
- First request: in the cycle after reset deassertion + 1 (BOOT). With imem_ready=1, if_valid=1 two edges after reset release.
- Latency:
  - Zero-wait memory: request at cycle n, instruction in slot at n+1.
  - Sustained throughput 1 instr/cycle with stall=0.
- Wait states: imem_req and imem_addr are held stable until imem_ready, unless slot_free drops (stall with full slot). In that case the request is withdrawn; memory must not assume commitment.
- stall with full slot: if_instr, if_pc, if_valid and pc are unchanged each cycle, and imem_req=0.
- Redirect takes effect on imem_addr the cycle after acceptance, or after the delay-slot fetch in PEND. No extra bubble beyond any squashed word.
- Reset mid-operation:
  - Outstanding request dropped, PEND/tgt discarded.
  - imem_req=0 during every reset cycle.

## Test plan
- Reset release, imem_ready=1, stall=0 -> imem_addr 3000,3004,3008 on consecutive cycles; if_pc follows one cycle later; if_pc8=300C for if_pc=3004.
- Slot full with if_pc=3008, stall=1 for 3 cycles -> imem_req=0, outputs frozen; stall drops -> fetch at 300C next cycle.
- Branch accepted with delay slot 3010 in slot, npc=3100, imem_ready=1 -> word from 3014 squashed (if_valid=0 next cycle), then if_pc=3100.
- imem_ready=0 when branch accepted, slot empty, pc=3010, npc=3200 -> state PEND; ready=1 two cycles later -> if_pc=3010 delivered, next if_pc=3200.
- branch=1 with stall=1, npc=3400 -> no redirect, pc unchanged; branch with stall=0 next cycle -> redirect to 3400.
- reset=0 asserted while in PEND with imem_req high -> next cycle imem_req=0, if_valid=0, pc=3000; fetch resumes at 3000 after BOOT.
